// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the fifo read-side stream controller.
// Optional statistics port is controlled by FIFO_READER_STATS_EN.
package fifo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SKID_DEPTH = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } reader_state_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream for fifo_stream_reader.
// The wordCount signal exists only when FIFO_READER_STATS_EN is defined.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH
) ();

    logic                 empty;
    logic [DataWidth-1:0] readData;
    logic                 readEn;
    logic                 flush;
    logic                 flushBusy;
    logic                 outValid;
    logic                 outReady;
    logic [DataWidth-1:0] outData;
`ifdef FIFO_READER_STATS_EN
    logic [31:0]          wordCount;
`endif

    // The reader itself is the master; the FIFO and consumer form the slave side.
    modport master (
        input  empty, readData, flush, outReady,
        output readEn, flushBusy, outValid, outData
`ifdef FIFO_READER_STATS_EN
        , output wordCount
`endif
    );

    modport slave (
        output empty, readData, flush, outReady,
        input  readEn, flushBusy, outValid, outData
`ifdef FIFO_READER_STATS_EN
        , input wordCount
`endif
    );

endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry skid buffer holding popped FIFO words until the consumer takes them.
// Not affected by FIFO_READER_STATS_EN.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic                 not_empty,
    output logic                 full,
    output logic [DataWidth-1:0] head
);

    logic [DataWidth-1:0] entry [SKID_DEPTH];
    logic [1:0]           occ;
    logic                 tail_idx;

    // A push lands at slot occ - pop, which is always 0 or 1 when a push is legal.
    assign tail_idx = (occ - {1'b0, pop}) != 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else if (clear) begin
            occ <= 2'd0;
        end else begin
            if (pop) begin
                entry[0] <= entry[1];
            end
            if (push) begin
                entry[tail_idx] <= push_data;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign not_empty = (occ != 2'd0);
    assign full      = (occ == 2'(SKID_DEPTH));
    assign head      = entry[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: pops the FIFO into a skid buffer, streams it out, supports flush.
// Define FIFO_READER_STATS_EN to add the wordCount handshake counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus
);

    reader_state_t        state;
    reader_state_t        state_next;
    logic                 read_en;
    logic                 flush_busy;
    logic                 push;
    logic                 clear;
    logic                 handshake;
    logic                 not_empty;
    logic                 full;
    logic [DataWidth-1:0] head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // readEn is gated by rst in both states so no pop is issued in a reset cycle.
    always_comb begin
        state_next = state;
        read_en    = 1'b0;
        flush_busy = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;
        case (state)
            RUN: begin
                read_en = !rst && !bus.empty && !full;
                push    = read_en;
                if (bus.flush) begin
                    state_next = FLUSH;
                    clear      = 1'b1;
                end
            end
            FLUSH: begin
                read_en    = !rst && !bus.empty;
                flush_busy = 1'b1;
                if (bus.empty) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign bus.readEn    = read_en;
    assign bus.flushBusy = flush_busy;
    assign bus.outValid  = not_empty && (state == RUN);
    assign bus.outData   = head;
    assign handshake     = bus.outValid && bus.outReady;

    fifo_skid_buf #(
        .DataWidth (DataWidth)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data (bus.readData),
        .pop       (handshake),
        .not_empty (not_empty),
        .full      (full),
        .head      (head)
    );

`ifdef FIFO_READER_STATS_EN
    logic [31:0] word_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= 32'd0;
        end else if (handshake) begin
            word_count <= word_count + 32'd1;
        end
    end

    assign bus.wordCount = word_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a behavioural FIFO model.
// Stats checks are compiled in only when FIFO_READER_STATS_EN is defined.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fifo_stream_reader_if #(.DataWidth(32)) bus ();

    fifo_stream_reader #(
        .DataWidth (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        model_clear = 1'b0;
    int          pop_count = 0;
    int          viol_count = 0;

    assign bus.empty    = (rd_ptr == wr_ptr);
    assign bus.readData = mem[rd_ptr[5:0]];

    // FIFO read side: pops on readEn, records any pop requested while empty.
    always @(posedge clk) begin
        if (bus.readEn) begin
            pop_count <= pop_count + 1;
            if (bus.empty) viol_count <= viol_count + 1;
        end
        if (model_clear) rd_ptr <= wr_ptr;
        else if (bus.readEn && !bus.empty) rd_ptr <= rd_ptr + 1;
    end

    task automatic push_word(input logic [31:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.outReady = 1'b0;
        repeat (2) @(negedge clk);
        push_word(32'hDEAD_0001);
        #1;
        checks++; if (bus.readEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_readEn got %0b want 0", bus.readEn); end
        @(negedge clk); #1;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outValid got %0b want 0", bus.outValid); end
        checks++; if (bus.flushBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_flushBusy got %0b want 0", bus.flushBusy); end
        checks++; if (bus.outData !== 32'h0) begin errors++; $display("[TB] FAIL reset_outData got %h want 0", bus.outData); end
`ifdef FIFO_READER_STATS_EN
        checks++; if (bus.wordCount !== 32'h0) begin errors++; $display("[TB] FAIL reset_wordCount got %h want 0", bus.wordCount); end
`endif
        model_clear = 1'b1;
        @(negedge clk);
        model_clear = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_streaming();
        @(negedge clk);
        bus.outReady = 1'b1;
        push_word(32'h11);
        #1;
        checks++; if (bus.readEn !== 1'b1) begin errors++; $display("[TB] FAIL stream_first_readEn got %0b want 1", bus.readEn); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_early_valid got %0b want 0", bus.outValid); end
        @(negedge clk); push_word(32'h22); #1;
        checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h11) begin errors++; $display("[TB] FAIL stream_word0 got v=%0b d=%h want v=1 d=11", bus.outValid, bus.outData); end
        @(negedge clk); push_word(32'h33); #1;
        checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h22) begin errors++; $display("[TB] FAIL stream_word1 got v=%0b d=%h want v=1 d=22", bus.outValid, bus.outData); end
        @(negedge clk); #1;
        checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h33) begin errors++; $display("[TB] FAIL stream_word2 got v=%0b d=%h want v=1 d=33", bus.outValid, bus.outData); end
        checks++; if (bus.readEn !== 1'b0) begin errors++; $display("[TB] FAIL stream_idle_readEn got %0b want 0", bus.readEn); end
        @(negedge clk); #1;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained got %0b want 0", bus.outValid); end
    endtask

    task automatic test_backpressure();
        int pc0;
        int rcv;
        @(negedge clk);
        bus.outReady = 1'b0;
        pc0 = pop_count;
        for (int i = 0; i < 5; i++) push_word(32'h101 + 32'(i));
        #1;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h101) begin errors++; $display("[TB] FAIL bp_hold cycle %0d got v=%0b d=%h want v=1 d=101", i, bus.outValid, bus.outData); end
        end
        checks++; if (pop_count - pc0 != 2) begin errors++; $display("[TB] FAIL bp_pops got %0d want 2", pop_count - pc0); end
        checks++; if (dut.u_skid.occ !== 2'd2) begin errors++; $display("[TB] FAIL bp_occ got %0d want 2", dut.u_skid.occ); end
        checks++; if (bus.readEn !== 1'b0) begin errors++; $display("[TB] FAIL bp_readEn got %0b want 0", bus.readEn); end
        rcv = 0;
        for (int c = 0; c < 20 && rcv < 5; c++) begin
            @(negedge clk);
            bus.outReady = 1'b1;
            #1;
            if (bus.outValid) begin
                checks++; if (bus.outData !== 32'h101 + 32'(rcv)) begin errors++; $display("[TB] FAIL bp_order idx %0d got %h want %h", rcv, bus.outData, 32'h101 + 32'(rcv)); end
                rcv++;
            end
        end
        checks++; if (rcv != 5) begin errors++; $display("[TB] FAIL bp_count got %0d want 5", rcv); end
        @(negedge clk); #1;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup got %0b want 0", bus.outValid); end
    endtask

    task automatic test_flush();
        int pc0;
        @(negedge clk);
        bus.outReady = 1'b0;
        for (int i = 0; i < 6; i++) push_word(32'h201 + 32'(i));
        #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++; if (dut.u_skid.occ !== 2'd2) begin errors++; $display("[TB] FAIL flush_setup_occ got %0d want 2", dut.u_skid.occ); end
        pc0 = pop_count;
        bus.flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.flush = 1'b0;
            #1;
            checks++; if (bus.outValid !== 1'b0 || bus.flushBusy !== 1'b1 || bus.readEn !== 1'b1) begin errors++; $display("[TB] FAIL flush_drain cycle %0d got v=%0b busy=%0b re=%0b want 0 1 1", i, bus.outValid, bus.flushBusy, bus.readEn); end
        end
        @(negedge clk); #1;
        checks++; if (bus.flushBusy !== 1'b1 || bus.readEn !== 1'b0) begin errors++; $display("[TB] FAIL flush_last_busy got busy=%0b re=%0b want 1 0", bus.flushBusy, bus.readEn); end
        checks++; if (pop_count - pc0 != 4) begin errors++; $display("[TB] FAIL flush_pops got %0d want 4", pop_count - pc0); end
        @(negedge clk);
        push_word(32'hAA);
        bus.outReady = 1'b1;
        #1;
        checks++; if (bus.flushBusy !== 1'b0 || bus.readEn !== 1'b1) begin errors++; $display("[TB] FAIL flush_exit got busy=%0b re=%0b want 0 1", bus.flushBusy, bus.readEn); end
        @(negedge clk); #1;
        checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'hAA) begin errors++; $display("[TB] FAIL flush_after_word got v=%0b d=%h want v=1 d=aa", bus.outValid, bus.outData); end
        @(negedge clk); #1;
    endtask

    task automatic test_flush_handshake();
        int c;
        int leaks;
        @(negedge clk);
        bus.outReady = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h5 + 32'(i));
        #1;
        @(negedge clk); #1;
        @(negedge clk);
        bus.outReady = 1'b1;
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h5) begin errors++; $display("[TB] FAIL fhs_handshake got v=%0b d=%h want v=1 d=5", bus.outValid, bus.outData); end
        c = 0;
        leaks = 0;
        do begin
            @(negedge clk);
            bus.flush = 1'b0;
            #1;
            if (bus.outValid) leaks++;
            c++;
        end while (bus.flushBusy && c < 20);
        checks++; if (leaks != 0) begin errors++; $display("[TB] FAIL fhs_no_delivery got %0d want 0", leaks); end
        checks++; if (c != 4) begin errors++; $display("[TB] FAIL fhs_busy_len got %0d want 4", c); end
`ifdef FIFO_READER_STATS_EN
        checks++; if (bus.wordCount !== 32'd10) begin errors++; $display("[TB] FAIL fhs_wordCount got %0d want 10", bus.wordCount); end
`endif
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        bus.outReady = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h301 + 32'(i));
        bus.flush = 1'b1;
        #1;
        @(negedge clk);
        bus.flush = 1'b0;
        rst = 1'b1;
        model_clear = 1'b1;
        #1;
        checks++; if (bus.readEn !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_readEn got %0b want 0", bus.readEn); end
        @(negedge clk);
        rst = 1'b0;
        model_clear = 1'b0;
        #1;
        checks++; if (bus.outValid !== 1'b0 || bus.flushBusy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outputs got v=%0b busy=%0b want 0 0", bus.outValid, bus.flushBusy); end
        checks++; if (bus.outData !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_outData got %h want 0", bus.outData); end
`ifdef FIFO_READER_STATS_EN
        checks++; if (bus.wordCount !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_wordCount got %h want 0", bus.wordCount); end
`endif
    endtask

`ifdef FIFO_READER_STATS_EN
    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.word_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.word_count;
        bus.outReady = 1'b1;
        push_word(32'h77);
        #1;
        checks++; if (bus.wordCount !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_preset got %h want ffffffff", bus.wordCount); end
        @(negedge clk); #1;
        checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h77) begin errors++; $display("[TB] FAIL wrap_word got v=%0b d=%h want v=1 d=77", bus.outValid, bus.outData); end
        @(negedge clk); #1;
        checks++; if (bus.wordCount !== 32'h0) begin errors++; $display("[TB] FAIL wrap_result got %h want 0", bus.wordCount); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        bus.flush = 1'b0;
        bus.outReady = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_flush_handshake();
        test_reset_mid_flush();
`ifdef FIFO_READER_STATS_EN
        test_counter_wrap();
`endif
        checks++; if (viol_count != 0) begin errors++; $display("[TB] FAIL readEn_while_empty got %0d want 0", viol_count); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
